// File: rtl/spi_rx_slave.sv
// spi_rx_slave: oversampled 12-bit LSB-first SPI receiver with a fall-through frame FIFO
//   clk, rst               system clock, asynchronous active-high reset
//   sclk, cs, mosi         SPI inputs, asynchronous to clk (cs active low)
//   dout, dout_valid       FIFO head frame and not-empty flag
//   dout_ready             consumer pops on valid && ready
//   fifo_count             frames currently stored
//   frame_err, overflow    1-cycle pulses: truncated frame, frame dropped on full FIFO
module spi_rx_slave #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sclk,
    input  logic                          cs,
    input  logic                          mosi,
    output logic [DATA_W-1:0]             dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, ARM, SHIFT, PUSH, WAIT_CS} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, vld_q;
    logic                   sclk_dly_q, cs_seen_q;
    logic                   sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]      sr_q, sr_d;
    logic                   push, pop, full, wr_en, frame_err_q, frame_err_d, overflow_q;
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;

    // vld_q marks when the synchroniser holds real samples rather than reset values;
    // cs_seen_q then requires a genuine cs=1 before any frame may start, so a frame
    // already in progress when reset is released is never captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            vld_q       <= '0;
            sclk_dly_q  <= 1'b0;
            cs_seen_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            sclk_dly_q  <= sclk_s;
            cs_seen_q   <= cs_seen_q | (vld_q[SYNC_STAGES-1] & cs_s);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sr_d        = sr_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: if (!cs_s && cs_seen_q) begin
                state_d = ARM;
                cnt_d   = '0;
                sr_d    = '0;
            end
            ARM: state_d = cs_s ? IDLE : (sclk_rise ? SHIFT : ARM);
            SHIFT: begin
                if (cs_s) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (sclk_fall) begin
                    sr_d    = {mosi_s, sr_q[DATA_W-1:1]};
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_q == CW'(DATA_W - 1)) ? PUSH : SHIFT;
                end
            end
            PUSH: begin
                push    = 1'b1;
                state_d = WAIT_CS;
            end
            WAIT_CS: state_d = cs_s ? IDLE : WAIT_CS;
            default: state_d = IDLE;
        endcase
    end

    assign dout_valid = wr_ptr_q != rd_ptr_q;
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = dout_valid && dout_ready;
    assign wr_en      = push && (!full || pop);
    assign dout       = mem_q[rd_ptr_q[AW-1:0]];
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= push && !wr_en;
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= sr_q;
                wr_ptr_q                <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end
endmodule

// File: tb/tb_spi_rx_slave.sv
// tb_spi_rx_slave: directed scoreboard bench for spi_rx_slave
module tb_spi_rx_slave;
    logic        clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs = 1'b1, mosi = 1'b0, dout_ready = 1'b0;
    logic [11:0] dout;
    logic        dout_valid, frame_err, overflow;
    logic [2:0]  fifo_count;
    logic [11:0] exp_q [$];
    logic [11:0] e;
    int          n_tests = 0, n_fail = 0, vcyc = 0, nferr = 0, novf = 0;

    spi_rx_slave dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .fifo_count(fifo_count), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // inputs change 2 time units after posedge; the monitor samples on negedge
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid) vcyc++;
            if (frame_err) nferr++;
            if (overflow) novf++;
            if (dout_valid && dout_ready) begin
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL pop_empty: got %h, nothing expected", dout);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_tests++;
                    assert (dout === e) else begin
                        n_fail++;
                        $error("FAIL dout: got %h expected %h", dout, e);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sbit(input logic b);
        mosi = b;
        sclk = 1'b1;
        tick(11);
        sclk = 1'b0;
        tick(11);
    endtask

    task automatic send(input logic [11:0] d, input int nbits, input int extra);
        cs = 1'b0;
        tick(3);
        for (int i = 0; i < nbits; i++) sbit(d[i]);
        for (int i = 0; i < extra; i++) sbit(1'b0);
        tick(3);
        cs = 1'b1;
        tick(8);
    endtask

    task automatic clr();
        vcyc = 0;
        nferr = 0;
        novf = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_dout"}, 32'(dout), 0);
        chk({tag, "_valid"}, 32'(dout_valid), 0);
        chk({tag, "_count"}, 32'(fifo_count), 0);
        chk({tag, "_ferr"}, 32'(frame_err), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
    endtask

    initial begin
        logic [11:0] d;
        tick(3);
        chk_reset("rst0");
        rst = 1'b0;
        tick(6);

        // 1: single frame, consumer always ready
        clr();
        dout_ready = 1'b1;
        exp_q.push_back(12'hA5C);
        send(12'hA5C, 12, 0);
        tick(4);
        chk("t1_valid_cycles", 32'(vcyc), 1);
        chk("t1_ferr", 32'(nferr), 0);
        chk("t1_ovf", 32'(novf), 0);
        chk("t1_pending", 32'(exp_q.size()), 0);

        // 2: fill FIFO, overflow, drain in order
        clr();
        dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = (i == 3) ? 12'h800 : 12'(1 << i);
            exp_q.push_back(d);
            send(d, 12, 0);
        end
        chk("t2_count_full", 32'(fifo_count), 4);
        send(12'hFFF, 12, 0);
        chk("t2_ovf", 32'(novf), 1);
        chk("t2_count_after_ovf", 32'(fifo_count), 4);
        dout_ready = 1'b1;
        tick(10);
        chk("t2_pending", 32'(exp_q.size()), 0);
        chk("t2_count_drained", 32'(fifo_count), 0);

        // 3: truncated frame, then a good one
        clr();
        send(12'h000, 5, 0);
        chk("t3_ferr", 32'(nferr), 1);
        chk("t3_count", 32'(fifo_count), 0);
        exp_q.push_back(12'h123);
        send(12'h123, 12, 0);
        tick(4);
        chk("t3_pending", 32'(exp_q.size()), 0);
        chk("t3_ferr_after", 32'(nferr), 1);

        // 4: extra sclk periods after a full frame
        clr();
        exp_q.push_back(12'h3C3);
        send(12'h3C3, 12, 3);
        tick(4);
        chk("t4_valid_cycles", 32'(vcyc), 1);
        chk("t4_ferr", 32'(nferr), 0);
        chk("t4_pending", 32'(exp_q.size()), 0);

        // 5: reset mid-frame with a frame parked in the FIFO
        dout_ready = 1'b0;
        send(12'h0AA, 12, 0);
        chk("t5_count_pre", 32'(fifo_count), 1);
        d = 12'h0F0;
        cs = 1'b0;
        tick(3);
        for (int i = 0; i < 7; i++) sbit(d[i]);
        rst = 1'b1;
        tick(1);
        chk_reset("t5_rst");
        rst = 1'b0;
        clr();
        for (int i = 7; i < 12; i++) sbit(d[i]);
        tick(3);
        cs = 1'b1;
        tick(8);
        chk("t5_ferr", 32'(nferr), 0);
        chk("t5_count", 32'(fifo_count), 0);
        chk("t5_valid_cycles", 32'(vcyc), 0);
        dout_ready = 1'b1;
        exp_q.push_back(12'h555);
        send(12'h555, 12, 0);
        tick(4);
        chk("t5_pending", 32'(exp_q.size()), 0);

        // 6: full FIFO, pop in the same cycle as the push
        dout_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            d = 12'(i * 12'h111);
            exp_q.push_back(d);
            send(d, 12, 0);
        end
        chk("t6_count_full", 32'(fifo_count), 4);
        clr();
        exp_q.push_back(12'h777);
        d = 12'h777;
        cs = 1'b0;
        tick(3);
        for (int i = 0; i < 11; i++) sbit(d[i]);
        mosi = d[11];
        sclk = 1'b1;
        tick(11);
        sclk = 1'b0;
        tick(3);
        dout_ready = 1'b1;
        tick(1);
        dout_ready = 1'b0;
        tick(8);
        cs = 1'b1;
        tick(8);
        chk("t6_ovf", 32'(novf), 0);
        chk("t6_count", 32'(fifo_count), 4);
        dout_ready = 1'b1;
        tick(10);
        chk("t6_pending", 32'(exp_q.size()), 0);
        chk("t6_count_drained", 32'(fifo_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
